// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult (with ha / fa ripple cells)
// Brief    : Unsigned radix-2 shift-and-add multiplier, WIDTH cycles/product.
// Revision : 1.0  initial release
// ============================================================================

module ha (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH:1]       w_carry;

    // A cleared multiplier bit adds zero, giving {1'b0, upper half} as the sum.
    assign w_addend = r_acc[0] ? r_mcand : '0;

    ha u_ha (
        .i_a (r_acc[WIDTH]),
        .i_b (w_addend[0]),
        .o_s (w_sum[0]),
        .o_c (w_carry[1])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        fa u_fa (
            .i_a (r_acc[WIDTH+i]),
            .i_b (w_addend[i]),
            .i_c (w_carry[i]),
            .o_s (w_sum[i]),
            .o_c (w_carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry out lands in the MSB; the consumed multiplier bit drops off.
                    r_acc <= {w_carry[WIDTH], w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign product   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult
// Brief    : Scoreboard bench for seq_mult at WIDTH=8 and WIDTH=16.
// Revision : 1.0  initial release
// ============================================================================

module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv     [2];
    logic        orr    [2];
    logic [15:0] av     [2];
    logic [15:0] bv     [2];
    logic        ir     [2];
    logic        ov     [2];
    logic        bz     [2];
    logic        dir_or [2];
    logic        rnd_or [2];
    logic [15:0] p8;
    logic [31:0] p16;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .a         (av[0][7:0]),
        .b         (bv[0][7:0]),
        .out_valid (ov[0]),
        .out_ready (orr[0]),
        .product   (p8),
        .busy      (bz[0])
    );

    seq_mult #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .a         (av[1]),
        .b         (bv[1]),
        .out_valid (ov[1]),
        .out_ready (orr[1]),
        .product   (p16),
        .busy      (bz[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepts push a*b, output handshakes pop and compare.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int W = (g == 0) ? 8 : 16;
        longint unsigned exp_q[$];
        int              lat_q[$];
        int              pend      = 0;
        logic            prev_ov   = 1'b0;
        logic            ready_due = 1'b0;
        logic [31:0]     prod_w;
        longint unsigned msk;
        int              lat;

        assign prod_w = (g == 0) ? {16'd0, p8} : p16;

        always @(negedge clk) begin
            msk = (64'd1 << W) - 64'd1;
            if (rst) begin
                exp_q.delete();
                lat_q.delete();
                pend      = 0;
                prev_ov   = 1'b0;
                ready_due = 1'b0;
            end else begin
                if (ready_due) begin
                    chk($sformatf("ready_after_out_w%0d", W), ir[g], 1);
                    ready_due = 1'b0;
                end
                chk($sformatf("busy_vs_ready_w%0d", W), bz[g], !ir[g]);
                if (iv[g] && ir[g]) begin
                    exp_q.push_back((longint'(av[g]) & msk) * (longint'(bv[g]) & msk));
                    lat_q.push_back(cyc + 1);
                    pend++;
                end
                if (ov[g]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output_w%0d actual=%0d expected=none t=%0t",
                                 W, prod_w, $time);
                    end else begin
                        if (!prev_ov && lat_q.size() > 0) begin
                            lat = lat_q.pop_front();
                            chk($sformatf("latency_w%0d", W), cyc - lat, W);
                        end
                        chk($sformatf("product_w%0d", W), prod_w, exp_q[0]);
                        if (orr[g]) begin
                            void'(exp_q.pop_front());
                            pend--;
                            ready_due = 1'b1;
                        end
                    end
                end
                prev_ov = ov[g];
            end
        end
    end

    function automatic int pend_of(input int d);
        return (d == 0) ? g_mon[0].pend : g_mon[1].pend;
    endfunction

    // Single driver for out_ready, offset from the edge so directed changes land cleanly.
    initial begin
        orr[0] = 1'b1;
        orr[1] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++)
                orr[k] = rnd_or[k] ? ($urandom_range(0, 2) != 0) : dir_or[k];
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int d, input logic [15:0] x, input logic [15:0] y);
        bit ok;
        ok    = 1'b0;
        av[d] = x;
        bv[d] = y;
        iv[d] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ir[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut=%0d actual=not_ready expected=ready", d);
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (pend_of(d) == 0 && ir[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout dut=%0d actual_pending=%0d expected=0", d, pend_of(d));
        end
    endtask

    function automatic logic [15:0] pick(input int d);
        logic [15:0] m;
        int          r;
        m = (d == 0) ? 16'h00FF : 16'hFFFF;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'd0;
        if (r == 1) return m;
        return 16'($urandom) & m;
    endfunction

    task automatic run_random(input int d, input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            issue(d, pick(d), pick(d));
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k]     = 1'b0;
            av[k]     = '0;
            bv[k]     = '0;
            dir_or[k] = 1'b1;
            rnd_or[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir[0], 1);
        chk("rst_out_valid", ov[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_product8", p8, 0);
        chk("rst_product16", p16, 0);
        rst = 1'b0;

        // Directed WIDTH=8 cases, including the all-ones carry case and zeros.
        issue(0, 16'd13, 16'd11);   wait_idle(0);
        issue(0, 16'd255, 16'd255); wait_idle(0);
        issue(0, 16'd0, 16'd200);   wait_idle(0);
        issue(0, 16'd200, 16'd0);   wait_idle(0);

        // Back-pressure with a competing operand pair held on the input.
        dir_or[0] = 1'b0;
        issue(0, 16'd7, 16'd9);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ov[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", seen, 1);
        @(posedge clk);
        #1;
        av[0] = 16'd99;
        bv[0] = 16'd99;
        iv[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", ov[0], 1);
            chk("bp_product_hold", p8, 63);
        end
        @(posedge clk);
        #1;
        iv[0]     = 1'b0;
        dir_or[0] = 1'b1;
        wait_idle(0);
        issue(0, 16'd21, 16'd6); wait_idle(0);

        // Asynchronous reset in the middle of a run.
        issue(0, 16'd100, 16'd50);
        repeat (4) @(posedge clk);
        #1;
        chk("midrun_busy", bz[0], 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", ir[0], 1);
        chk("arst_out_valid", ov[0], 0);
        chk("arst_busy", bz[0], 0);
        chk("arst_product", p8, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 16'd3, 16'd5); wait_idle(0);

        // Random traffic on both widths concurrently.
        rnd_or[0] = 1'b1;
        rnd_or[1] = 1'b1;
        fork
            run_random(0, 1000);
            run_random(1, 1000);
        join
        wait_idle(0);
        wait_idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
